nibble_serial_tx: RTL and testbench
===================================

NIBBLE_SERIAL_TX -- requirements
Module: nibble_serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit; legal range 2..255.
REQ-002 Parameter PARITY_EN, default 1: 1 inserts an even-parity bit after the data bits, 0 omits it.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 tx_en  input  1  enable for starting new frames.
REQ-006 fifo_empty  input  1  empty flag from the upstream 4x4 FIFO.
REQ-007 fifo_data  input  4  registered read data from the upstream FIFO.
REQ-008 fifo_pop  output  1  registered one-cycle read strobe to the upstream FIFO.
REQ-009 tx_out  output  1  serial line, idle high.
REQ-010 busy  output  1  high from POP through STOP inclusive.
REQ-011 frame_done  output  1  one-cycle pulse during the last cycle of the stop bit.

Function
REQ-012 The FSM SHALL have the states IDLE, POP, CAPTURE, START, DATA, PARITY and STOP.
REQ-013 IDLE: if tx_en=1 and fifo_empty=0, go to POP; otherwise stay in IDLE with tx_out=1.
REQ-014 POP: fifo_pop=1 for exactly one cycle, then go to CAPTURE; fifo_pop SHALL be 0 in every other state.
REQ-015 CAPTURE: latch fifo_data into a 4-bit shift register at the end of this cycle; this gives a 1-cycle read latency after the pop strobe. Compute parity as the XOR of the 4 bits.
REQ-016 START: tx_out=0 for CLKS_PER_BIT cycles.
REQ-017 DATA: send 4 bits LSB first, each for CLKS_PER_BIT cycles; a 2-bit index counts 0..3.
REQ-018 PARITY: entered only when PARITY_EN=1; tx_out=parity for CLKS_PER_BIT cycles.
REQ-019 STOP: tx_out=1 for CLKS_PER_BIT cycles; frame_done=1 in the final cycle; then go to IDLE.
REQ-020 Frame length SHALL be 7*CLKS_PER_BIT cycles with parity, or 6*CLKS_PER_BIT cycles without.
REQ-021 Back-to-back frames: the minimum line-high gap between the end of STOP and the next start bit SHALL be 3 cycles (IDLE, POP, CAPTURE).
REQ-022 fifo_empty SHALL be sampled only in IDLE; at most one pop is issued per frame, which also covers the upstream empty-flag lag.
REQ-023 tx_en deasserted mid-frame: the current frame SHALL complete, and no further pop is issued.
REQ-024 The bit-timing counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and wrap to 0 at each bit boundary.

Reset
REQ-025 While reset_n=0 at a rising edge, the block SHALL set: state=IDLE, tx_out=1, fifo_pop=0, busy=0, frame_done=0, and all counters and the shift register to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame at the next edge: line high, no frame_done, and the captured word is discarded.
REQ-027 Reset SHALL take priority over every other condition.

Structure
REQ-028 The shared package nibble_tx_pkg SHALL hold the state enum, the 4-bit data width constant and the idle/start/stop line-level constants.
REQ-029 The bit-timing counter SHALL be a sub-module, baud_tick_gen, parameterised by CLKS_PER_BIT, with inputs clear and enable and a single output tick.

Verification
REQ-030 Reset: reset_n=0 for 2 cycles mid-activity -> tx_out=1, fifo_pop=0, busy=0, frame_done=0.
REQ-031 Single word, CLKS_PER_BIT=4, PARITY_EN=1, fifo_data=4'b1011:
- fifo_pop is high for 1 cycle;
- tx_out is 0,1,1,0,1,1,1, each held 4 cycles (28 cycles total);
- frame_done pulses once, in cycle 28.
REQ-032 Back-to-back words 4'h3 then 4'hC -> exactly 2 pops; tx_out stays high for 3 cycles between frames; the second frame's parity bit is 0.
REQ-033 fifo_empty=1, tx_en=1 for 50 cycles -> fifo_pop never asserts, tx_out=1, busy=0.
REQ-034 Reset during data bit 2 -> at the next edge tx_out=1 and the state is IDLE; no frame_done follows.
REQ-035 PARITY_EN=0 with tx_en dropped during DATA -> the frame ends after 24 cycles, and no further pop occurs although fifo_empty=0.

Source files
------------

// File: rtl/nibble_tx_pkg.sv
// -----------------------------------------------------------------------------
// nibble_tx_pkg
// Shared definitions for the nibble serial transmitter:
//   - tx_state_t : transmitter FSM states
//   - DATA_W     : width of one transmitted word (a nibble)
//   - LINE_*     : serial line levels for idle, start and stop
//   - even_parity: parity bit that makes the total number of ones even
// -----------------------------------------------------------------------------
package nibble_tx_pkg;

    localparam int DATA_W = 4;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_START   = 3'd3,
        ST_DATA    = 3'd4,
        ST_PARITY  = 3'd5,
        ST_STOP    = 3'd6
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Bit-timing counter. Counts 0..CLKS_PER_BIT-1 while enabled and wraps to 0 at
// each bit boundary; tick is high in the last clock of every bit period.
// Ports:
//   clk      in  1  clock
//   reset_n  in  1  synchronous active-low reset (counter to 0)
//   clear    in  1  force the counter back to 0 (bit period restarts)
//   enable   in  1  advance the counter
//   tick     out 1  last cycle of the current bit period
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign tick = enable && (cnt_reg == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nibble_serial_tx.sv
// -----------------------------------------------------------------------------
// nibble_serial_tx
// Pulls 4-bit words from an upstream FIFO (registered read data, one cycle of
// latency after the pop strobe) and sends each one as a serial frame:
// start bit, 4 data bits LSB first, optional even-parity bit, stop bit.
// Ports:
//   clk         in  1  clock
//   reset_n     in  1  synchronous active-low reset, aborts any frame
//   tx_en       in  1  allow new frames to start (checked only in IDLE)
//   fifo_empty  in  1  upstream FIFO empty flag
//   fifo_data   in  4  upstream FIFO read data
//   fifo_pop    out 1  one-cycle read strobe
//   tx_out      out 1  serial line, idle high
//   busy        out 1  high from POP through STOP
//   frame_done  out 1  high in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module nibble_serial_tx
    import nibble_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_pop,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    tx_state_t         state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              parity_reg;
    logic [1:0]        bit_idx_reg;
    logic              tx_out_reg;
    logic              fifo_pop_reg;
    logic              busy_reg;

    logic bit_clear;
    logic bit_en;
    logic tick;

    // The bit timer only runs while a bit is on the line; in the setup
    // states it is held at 0 so START always gets a full bit period.
    assign bit_clear = (state_reg == ST_IDLE) || (state_reg == ST_POP) ||
                       (state_reg == ST_CAPTURE);
    assign bit_en    = !bit_clear;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (bit_clear),
        .enable (bit_en),
        .tick   (tick)
    );

    assign fifo_pop   = fifo_pop_reg;
    assign tx_out     = tx_out_reg;
    assign busy       = busy_reg;
    // Decoded from two registers so it lines up exactly with the last stop
    // cycle; it falls away on reset because the state returns to IDLE.
    assign frame_done = (state_reg == ST_STOP) && tick;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            bit_idx_reg  <= 2'd0;
            tx_out_reg   <= LINE_IDLE;
            fifo_pop_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            fifo_pop_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tx_out_reg <= LINE_IDLE;
                    busy_reg   <= 1'b0;
                    // fifo_empty is only looked at here, so a lagging empty
                    // flag can never cause a second pop within one frame.
                    if (tx_en && !fifo_empty) begin
                        state_reg    <= ST_POP;
                        fifo_pop_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                    end
                end
                ST_POP: begin
                    state_reg <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // Read data is valid now, one cycle after the strobe.
                    shift_reg   <= fifo_data;
                    parity_reg  <= even_parity(fifo_data);
                    bit_idx_reg <= 2'd0;
                    tx_out_reg  <= LINE_START;
                    state_reg   <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        tx_out_reg <= shift_reg[0];
                        state_reg  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx_reg == 2'd3) begin
                            if (PARITY_EN != 0) begin
                                tx_out_reg <= parity_reg;
                                state_reg  <= ST_PARITY;
                            end else begin
                                tx_out_reg <= LINE_STOP;
                                state_reg  <= ST_STOP;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 2'd1;
                            shift_reg   <= shift_reg >> 1;
                            tx_out_reg  <= shift_reg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_out_reg <= LINE_STOP;
                        state_reg  <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    tx_out_reg <= LINE_IDLE;
                    busy_reg   <= 1'b0;
                    state_reg  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_tx
// Directed bench for nibble_serial_tx. dut_a runs with parity, dut_b without;
// each is fed by a small FIFO model with registered read data.
// -----------------------------------------------------------------------------
module tb_nibble_serial_tx;
    import nibble_tx_pkg::*;

    localparam int MAXC = 80;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       tx_en_a = 1'b0;
    logic       fifo_empty_a;
    logic [3:0] fifo_data_a = 4'h0;
    logic       fifo_pop_a, tx_out_a, busy_a, frame_done_a;

    logic       tx_en_b = 1'b0;
    logic       fifo_empty_b;
    logic [3:0] fifo_data_b = 4'h0;
    logic       fifo_pop_b, tx_out_b, busy_b, frame_done_b;

    always #5 clk = ~clk;

    nibble_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_en     (tx_en_a),
        .fifo_empty(fifo_empty_a),
        .fifo_data (fifo_data_a),
        .fifo_pop  (fifo_pop_a),
        .tx_out    (tx_out_a),
        .busy      (busy_a),
        .frame_done(frame_done_a)
    );

    nibble_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .tx_en     (tx_en_b),
        .fifo_empty(fifo_empty_b),
        .fifo_data (fifo_data_b),
        .fifo_pop  (fifo_pop_b),
        .tx_out    (tx_out_b),
        .busy      (busy_b),
        .frame_done(frame_done_b)
    );

    // FIFO models: initial block owns the write side, always blocks own reads.
    logic [3:0] mem_a [0:15];
    logic [3:0] mem_b [0:15];
    int wr_a = 0;
    int rd_a = 0;
    int wr_b = 0;
    int rd_b = 0;

    assign fifo_empty_a = (wr_a == rd_a);
    assign fifo_empty_b = (wr_b == rd_b);

    always @(posedge clk) begin
        if (fifo_pop_a) begin
            fifo_data_a <= mem_a[rd_a[3:0]];
            rd_a        <= rd_a + 1;
        end
    end

    always @(posedge clk) begin
        if (fifo_pop_b) begin
            fifo_data_b <= mem_b[rd_b[3:0]];
            rd_b        <= rd_b + 1;
        end
    end

    // Captured samples, index n = negedge number after the capture starts.
    logic tx_a_s   [0:MAXC];
    logic pop_a_s  [0:MAXC];
    logic done_a_s [0:MAXC];
    logic busy_a_s [0:MAXC];
    logic tx_b_s   [0:MAXC];
    int pop_cnt_a, done_cnt_a, done_first_a, done_last_a, low_cnt_a, busy_cnt_a;
    int pop_cnt_b, done_cnt_b, done_first_b;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [3:0] v);
        mem_a[wr_a[3:0]] = v;
        wr_a = wr_a + 1;
    endtask

    task automatic push_b(input logic [3:0] v);
        mem_b[wr_b[3:0]] = v;
        wr_b = wr_b + 1;
    endtask

    // Samples both DUTs on ncyc falling edges; drops tx_en_b at drop_b_at.
    task automatic capture(input int ncyc, input int drop_b_at);
        pop_cnt_a = 0; done_cnt_a = 0; done_first_a = -1; done_last_a = -1;
        low_cnt_a = 0; busy_cnt_a = 0;
        pop_cnt_b = 0; done_cnt_b = 0; done_first_b = -1;
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            tx_a_s[n]   = tx_out_a;
            pop_a_s[n]  = fifo_pop_a;
            done_a_s[n] = frame_done_a;
            busy_a_s[n] = busy_a;
            tx_b_s[n]   = tx_out_b;
            if (fifo_pop_a)   pop_cnt_a++;
            if (busy_a)       busy_cnt_a++;
            if (!tx_out_a)    low_cnt_a++;
            if (frame_done_a) begin
                done_cnt_a++;
                if (done_first_a < 0) done_first_a = n;
                done_last_a = n;
            end
            if (fifo_pop_b)   pop_cnt_b++;
            if (frame_done_b) begin
                done_cnt_b++;
                if (done_first_b < 0) done_first_b = n;
            end
            if (n == drop_b_at) tx_en_b = 1'b0;
        end
    endtask

    initial begin
        logic [6:0] slots;
        logic       exp_tx;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_tx_a",   tx_out_a,     1);
        check_eq("rst_pop_a",  fifo_pop_a,   0);
        check_eq("rst_busy_a", busy_a,       0);
        check_eq("rst_done_a", frame_done_a, 0);
        check_eq("rst_tx_b",   tx_out_b,     1);
        check_eq("rst_busy_b", busy_b,       0);
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset released: tx_a=%0b busy_a=%0b", tx_out_a, busy_a);

        // Single word 1011 with parity: start,1,1,0,1,parity=1,stop
        push_a(4'b1011);
        tx_en_a = 1'b1;
        capture(34, 0);
        slots = 7'b1110110;
        for (int n = 1; n <= 32; n++) begin
            if (n < 3 || n > 30) exp_tx = 1'b1;
            else                 exp_tx = slots[(n - 3) / 4];
            check_eq($sformatf("single_tx_n%0d", n), tx_a_s[n], exp_tx);
        end
        check_eq("single_pop_cnt",   pop_cnt_a,    1);
        check_eq("single_pop_cycle", pop_a_s[1],   1);
        check_eq("single_done_cnt",  done_cnt_a,   1);
        check_eq("single_done_cyc",  done_first_a - 2, 28);
        check_eq("single_busy_pop",  busy_a_s[1],  1);
        check_eq("single_busy_stop", busy_a_s[30], 1);
        check_eq("single_busy_end",  busy_a_s[31], 0);
        $display("single word 0xb: pops=%0d done_at=%0d", pop_cnt_a, done_first_a);

        // Back-to-back 3 then C
        push_a(4'h3);
        push_a(4'hC);
        capture(70, 0);
        check_eq("b2b_pop_cnt",    pop_cnt_a,    2);
        check_eq("b2b_done_cnt",   done_cnt_a,   2);
        check_eq("b2b_done_first", done_first_a, 30);
        check_eq("b2b_done_last",  done_last_a,  61);
        check_eq("b2b_gap", {tx_a_s[31], tx_a_s[32], tx_a_s[33], tx_a_s[34]}, 4'b1110);
        check_eq("b2b_f1_data", {tx_a_s[9], tx_a_s[13], tx_a_s[17], tx_a_s[21]}, 4'b1100);
        check_eq("b2b_f1_par",  tx_a_s[24], 0);
        check_eq("b2b_f2_data", {tx_a_s[40], tx_a_s[44], tx_a_s[48], tx_a_s[52]}, 4'b0011);
        check_eq("b2b_f2_par",  {tx_a_s[54], tx_a_s[55], tx_a_s[56], tx_a_s[57]}, 4'b0000);
        $display("back-to-back 0x3,0xc: pops=%0d done_at=%0d,%0d", pop_cnt_a, done_first_a, done_last_a);

        // Empty FIFO with tx_en high for 50 cycles
        capture(50, 0);
        check_eq("empty_pops", pop_cnt_a,  0);
        check_eq("empty_low",  low_cnt_a,  0);
        check_eq("empty_busy", busy_cnt_a, 0);
        $display("empty fifo 50 cycles: pops=%0d busy=%0d", pop_cnt_a, busy_cnt_a);

        // Reset during data bit 2 (word 1010: bit2 = 0)
        push_a(4'b1010);
        for (int n = 1; n <= 16; n++) @(negedge clk);
        check_eq("mid_bit2_tx", tx_out_a, 0);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("mid_rst_tx",    tx_out_a,     1);
        check_eq("mid_rst_state", 32'(dut_a.state_reg), 32'(ST_IDLE));
        check_eq("mid_rst_busy",  busy_a,       0);
        check_eq("mid_rst_pop",   fifo_pop_a,   0);
        check_eq("mid_rst_done",  frame_done_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tx_en_a = 1'b0;
        capture(40, 0);
        check_eq("mid_rst_no_done", done_cnt_a, 0);
        check_eq("mid_rst_line_hi", low_cnt_a,  0);
        $display("reset in data bit 2: done after=%0d low after=%0d", done_cnt_a, low_cnt_a);

        // No parity, tx_en dropped during DATA, second word left in FIFO
        push_b(4'h5);
        push_b(4'h6);
        tx_en_b = 1'b1;
        capture(60, 10);
        check_eq("np_pop_cnt",  pop_cnt_b,    1);
        check_eq("np_done_cnt", done_cnt_b,   1);
        check_eq("np_done_cyc", done_first_b - 2, 24);
        check_eq("np_bits", {tx_b_s[4], tx_b_s[8], tx_b_s[12], tx_b_s[16], tx_b_s[20], tx_b_s[24]}, 6'b010101);
        check_eq("np_idle_after", tx_b_s[27], 1);
        $display("no parity 0x5, tx_en dropped: pops=%0d done_at=%0d", pop_cnt_b, done_first_b);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
